// File: rtl/dpd_adapt_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dpd_adapt_sched_pkg
//  Brief    : Shared types for the DPD adaptation sequencer.
//  Revision : 1.0
// ============================================================================
package dpd_adapt_sched_pkg;

   localparam int CNT_W = 16;

   typedef logic [7:0] u8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } dpd_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/dpd_adapt_sched_win_gen.sv
`default_nettype none
// ============================================================================
//  Module   : dpd_win_gen
//  Brief    : Registered window flag, high one cycle after LO <= cnt <= HI
//             while run is asserted.
//  Revision : 1.0
// ============================================================================
module dpd_win_gen #(
   parameter int LO = 1,
   parameter int HI = 1,
   parameter int W  = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_run,
   input  logic [W-1:0] i_cnt,
   output logic         o_win
);

   localparam logic [W-1:0] c_LO = W'(LO);
   localparam logic [W-1:0] c_HI = W'(HI);

   logic r_win;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_win <= 1'b0;
      end else begin
         r_win <= i_run && (i_cnt >= c_LO) && (i_cnt <= c_HI);
      end
   end

   assign o_win = r_win;

endmodule
`default_nettype wire

// File: rtl/dpd_adapt_sched.sv
`default_nettype none
// ============================================================================
//  Module   : dpd_adapt_sched
//  Brief    : DPD LMS adaptation sequencer; N_ITER bursts of sig/sw/coef
//             windows per request. Optional macro: DPD_AUTO_READAPT_EN.
//  Revision : 1.0
// ============================================================================
module dpd_adapt_sched
   import dpd_adapt_sched_pkg::*;
#(
   parameter int DELAY      = 41,
   parameter int SIG_LEN    = 800,
   parameter int COEF_START = 150,
   parameter int COEF_END   = 700,
   parameter int GAP_LEN    = 64,
   parameter int N_ITER     = 4,
   parameter int PERIOD     = 1 << 20
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic abort,
   output logic busy,
   output logic done,
   output logic aborted,
   output logic sig_win,
   output logic sw_win,
   output logic coef_win,
   output u8    iter_cnt
);

   if (DELAY + SIG_LEN + 1 >= (1 << CNT_W)) begin : g_chk_burst_len
      $fatal(1, "dpd_adapt_sched: DELAY+SIG_LEN+1 does not fit the burst counter");
   end
   if (COEF_START > COEF_END || COEF_END > SIG_LEN) begin : g_chk_coef
      $fatal(1, "dpd_adapt_sched: coefficient window outside training burst");
   end
   if (GAP_LEN < 1 || GAP_LEN >= (1 << CNT_W) || N_ITER < 1 || N_ITER > 255) begin : g_chk_gap_iter
      $fatal(1, "dpd_adapt_sched: GAP_LEN or N_ITER out of range");
   end
   if (PERIOD < 2 || PERIOD > (1 << 24)) begin : g_chk_period
      $fatal(1, "dpd_adapt_sched: PERIOD out of range");
   end

   localparam logic [CNT_W-1:0] c_BURST_END = CNT_W'(DELAY + SIG_LEN + 1);
   localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_LEN - 1);
   localparam u8                c_LAST_ITER = 8'(N_ITER - 1);

   dpd_sched_state_t r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   u8                r_iter, w_iter_nxt;
   logic             r_busy, r_done, r_aborted;
   logic             w_start;
   logic             w_run;

`ifdef DPD_AUTO_READAPT_EN
   localparam logic [23:0] c_TMR_LAST = 24'(PERIOD - 1);

   logic [23:0] r_idle_tmr;
   logic        w_auto_start;

   assign w_auto_start = (r_state == IDLE) && (r_idle_tmr == c_TMR_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idle_tmr <= '0;
      end else if (r_state != IDLE || abort || w_auto_start) begin
         r_idle_tmr <= '0;
      end else begin
         r_idle_tmr <= r_idle_tmr + 24'd1;
      end
   end

   assign w_start = start | w_auto_start;
`else
   assign w_start = start;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_iter_nxt  = r_iter;
      case (r_state)
         IDLE: begin
            if (!abort && w_start) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
               w_iter_nxt  = '0;
            end
         end
         RUN: begin
            if (abort) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_BURST_END) begin
               w_state_nxt = (r_iter < c_LAST_ITER) ? GAP : DONE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         GAP: begin
            if (abort) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_GAP_LAST) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
               w_iter_nxt  = r_iter + 8'd1;
            end else begin
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_iter  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_iter  <= w_iter_nxt;
      end
   end

   // Status flags lag the state by one cycle, like the windows; abort masks them at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_busy    <= ((r_state == RUN) || (r_state == GAP)) && !abort;
         r_done    <= (r_state == DONE) && !abort;
         r_aborted <= (r_state != IDLE) && abort;
      end
   end

   assign w_run = (r_state == RUN) && !abort;

   dpd_win_gen #(.LO(1), .HI(SIG_LEN), .W(CNT_W)) u_sig_win (
      .clk(clk), .reset(reset), .i_run(w_run), .i_cnt(r_cnt), .o_win(sig_win)
   );

   dpd_win_gen #(.LO(DELAY + 1), .HI(DELAY + SIG_LEN), .W(CNT_W)) u_sw_win (
      .clk(clk), .reset(reset), .i_run(w_run), .i_cnt(r_cnt), .o_win(sw_win)
   );

   dpd_win_gen #(.LO(DELAY + COEF_START), .HI(DELAY + COEF_END), .W(CNT_W)) u_coef_win (
      .clk(clk), .reset(reset), .i_run(w_run), .i_cnt(r_cnt), .o_win(coef_win)
   );

   assign busy     = r_busy;
   assign done     = r_done;
   assign aborted  = r_aborted;
   assign iter_cnt = r_iter;

endmodule
`default_nettype wire
